// File: rtl/control_unit_if.sv
// control_unit_if: opcode/flag/stop inputs and every control strobe the
// sequencer hands to the Mini-SRC datapath, bundled as one port.
interface control_unit_if;
    logic [4:0] opcode;
    logic       CON_FF;
    logic       stop;

    logic       run;
    logic       PCout, ZLowout, ZHighout, MDRout, HIout, LOout;
    logic       InPortout, Cout, BAout, Rout;
    logic       Gra, Grb, Grc;
    logic       R_enable, R15in;
    logic       enableMAR, enableMDR, enableIR, enableY, enableZ, enablePC;
    logic       enableHI, enableLO, enableCON, enableInPort, enableOutPort;
    logic [2:0] MDR_read;
    logic       RAM_write;
    logic       IncPC;

    // The control unit side drives every strobe and reads the datapath status.
    modport master (
        input  opcode, CON_FF, stop,
        output run, PCout, ZLowout, ZHighout, MDRout, HIout, LOout,
               InPortout, Cout, BAout, Rout, Gra, Grb, Grc, R_enable, R15in,
               enableMAR, enableMDR, enableIR, enableY, enableZ, enablePC,
               enableHI, enableLO, enableCON, enableInPort, enableOutPort,
               MDR_read, RAM_write, IncPC
    );

    // The datapath side supplies status and consumes the strobes.
    modport slave (
        output opcode, CON_FF, stop,
        input  run, PCout, ZLowout, ZHighout, MDRout, HIout, LOout,
               InPortout, Cout, BAout, Rout, Gra, Grb, Grc, R_enable, R15in,
               enableMAR, enableMDR, enableIR, enableY, enableZ, enablePC,
               enableHI, enableLO, enableCON, enableInPort, enableOutPort,
               MDR_read, RAM_write, IncPC
    );
endinterface

// File: rtl/control_unit.sv
// control_unit: hardwired Mini-SRC sequencer. Fetch is T0-T2, execute is
// T3-T7 depending on the opcode latched at the end of T2. Strobes are a
// Moore decode of the step plus the latched opcode (br also looks at CON_FF).
module control_unit #(
    parameter bit RESET_PC_LOAD = 1'b0,
    parameter int OPW           = 5
) (
    input  logic           clk,
    input  logic           clr,
    control_unit_if.master cu
);
    typedef enum logic [3:0] {RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;

    typedef enum logic [3:0] {
        C_NONE, C_ALU, C_IMM, C_LDI, C_LD, C_ST, C_MULDIV, C_NEGNOT,
        C_BR, C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO
    } opclass_t;

    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11010);

    state_t         state_q, state_d;
    logic [OPW-1:0] opcode_q;
    opclass_t       liveClass, heldClass;
    state_t         lastStep;

    // Groups opcodes that share one execute sequence; nop, halt and
    // undefined codes have no execute steps at all.
    function automatic opclass_t classify(input logic [OPW-1:0] op);
        opclass_t c;
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b00111, 5'b01000, 5'b01001, 5'b01010: c = C_ALU;
            5'b01011, 5'b01100, 5'b01101:           c = C_IMM;
            5'b00001:                               c = C_LDI;
            5'b00000:                               c = C_LD;
            5'b00010:                               c = C_ST;
            5'b01110, 5'b01111:                     c = C_MULDIV;
            5'b10000, 5'b10001:                     c = C_NEGNOT;
            5'b10010:                               c = C_BR;
            5'b10011:                               c = C_JR;
            5'b10100:                               c = C_JAL;
            5'b10101:                               c = C_IN;
            5'b10110:                               c = C_OUT;
            5'b10111:                               c = C_MFHI;
            5'b11000:                               c = C_MFLO;
            default:                                c = C_NONE;
        endcase
        return c;
    endfunction

    // Final execute step of each instruction group.
    function automatic state_t finalStep(input opclass_t c);
        state_t s;
        case (c)
            C_ALU, C_IMM, C_LDI: s = T5;
            C_LD, C_ST:          s = T7;
            C_MULDIV, C_BR:      s = T6;
            C_NEGNOT, C_JAL:     s = T4;
            default:             s = T3;
        endcase
        return s;
    endfunction

    assign liveClass = classify(cu.opcode);
    assign heldClass = classify(opcode_q);
    assign lastStep  = finalStep(heldClass);

    // Step register and the opcode copy captured on the T2->T3 edge; clr wins over everything.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q  <= RESET;
            opcode_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == T2) begin
                opcode_q <= cu.opcode;
            end
        end
    end

    // Next-step selection plus the Moore strobe decode for the current step.
    always_comb begin
        state_d          = state_q;
        cu.run           = (state_q != RESET) && (state_q != HALT);
        cu.PCout         = 1'b0;
        cu.ZLowout       = 1'b0;
        cu.ZHighout      = 1'b0;
        cu.MDRout        = 1'b0;
        cu.HIout         = 1'b0;
        cu.LOout         = 1'b0;
        cu.InPortout     = 1'b0;
        cu.Cout          = 1'b0;
        cu.BAout         = 1'b0;
        cu.Rout          = 1'b0;
        cu.Gra           = 1'b0;
        cu.Grb           = 1'b0;
        cu.Grc           = 1'b0;
        cu.R_enable      = 1'b0;
        cu.R15in         = 1'b0;
        cu.enableMAR     = 1'b0;
        cu.enableMDR     = 1'b0;
        cu.enableIR      = 1'b0;
        cu.enableY       = 1'b0;
        cu.enableZ       = 1'b0;
        cu.enablePC      = 1'b0;
        cu.enableHI      = 1'b0;
        cu.enableLO      = 1'b0;
        cu.enableCON     = 1'b0;
        cu.enableInPort  = 1'b0;
        cu.enableOutPort = 1'b0;
        cu.MDR_read      = 3'd0;
        cu.RAM_write     = 1'b0;
        cu.IncPC         = 1'b0;

        case (state_q)
            RESET: begin
                state_d     = T0;
                cu.enablePC = RESET_PC_LOAD;
            end
            T0: begin
                state_d      = T1;
                cu.PCout     = 1'b1;
                cu.enableMAR = 1'b1;
                cu.IncPC     = 1'b1;
                cu.enableZ   = 1'b1;
            end
            T1: begin
                state_d      = T2;
                cu.ZLowout   = 1'b1;
                cu.enablePC  = 1'b1;
                cu.enableMDR = 1'b1;
                cu.MDR_read  = 3'd1;
            end
            T2: begin
                cu.MDRout   = 1'b1;
                cu.enableIR = 1'b1;
                if (cu.opcode == OP_HALT) begin
                    state_d = HALT;
                end else if (liveClass == C_NONE) begin
                    state_d = cu.stop ? HALT : T0;
                end else begin
                    state_d = T3;
                end
            end
            T3, T4, T5, T6, T7: begin
                if (state_q == lastStep) begin
                    state_d = cu.stop ? HALT : T0;
                end else begin
                    case (state_q)
                        T3:      state_d = T4;
                        T4:      state_d = T5;
                        T5:      state_d = T6;
                        T6:      state_d = T7;
                        default: state_d = T0;
                    endcase
                end

                case (state_q)
                    T3: begin
                        case (heldClass)
                            C_ALU, C_IMM:       begin cu.Grb = 1'b1; cu.Rout = 1'b1; cu.enableY = 1'b1; end
                            C_LDI, C_LD, C_ST:  begin cu.Grb = 1'b1; cu.BAout = 1'b1; cu.enableY = 1'b1; end
                            C_MULDIV:           begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.enableY = 1'b1; end
                            C_NEGNOT:           begin cu.Grb = 1'b1; cu.Rout = 1'b1; cu.enableZ = 1'b1; end
                            C_BR:               begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.enableCON = 1'b1; end
                            C_JR:               begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.enablePC = 1'b1; end
                            C_JAL:              begin cu.PCout = 1'b1; cu.R15in = 1'b1; end
                            C_IN:               begin cu.InPortout = 1'b1; cu.Gra = 1'b1; cu.R_enable = 1'b1; end
                            C_OUT:              begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.enableOutPort = 1'b1; end
                            C_MFHI:             begin cu.HIout = 1'b1; cu.Gra = 1'b1; cu.R_enable = 1'b1; end
                            C_MFLO:             begin cu.LOout = 1'b1; cu.Gra = 1'b1; cu.R_enable = 1'b1; end
                            default:            ;
                        endcase
                    end
                    T4: begin
                        case (heldClass)
                            C_ALU:                    begin cu.Grc = 1'b1; cu.Rout = 1'b1; cu.enableZ = 1'b1; end
                            C_IMM, C_LDI, C_LD, C_ST: begin cu.Cout = 1'b1; cu.enableZ = 1'b1; end
                            C_MULDIV:                 begin cu.Grb = 1'b1; cu.Rout = 1'b1; cu.enableZ = 1'b1; end
                            C_NEGNOT:                 begin cu.ZLowout = 1'b1; cu.Gra = 1'b1; cu.R_enable = 1'b1; end
                            C_BR:                     begin cu.PCout = 1'b1; cu.enableY = 1'b1; end
                            C_JAL:                    begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.enablePC = 1'b1; end
                            default:                  ;
                        endcase
                    end
                    T5: begin
                        case (heldClass)
                            C_ALU, C_IMM, C_LDI: begin cu.ZLowout = 1'b1; cu.Gra = 1'b1; cu.R_enable = 1'b1; end
                            C_LD, C_ST:          begin cu.ZLowout = 1'b1; cu.enableMAR = 1'b1; end
                            C_MULDIV:            begin cu.ZLowout = 1'b1; cu.enableLO = 1'b1; end
                            C_BR:                begin cu.Cout = 1'b1; cu.enableZ = 1'b1; end
                            default:             ;
                        endcase
                    end
                    T6: begin
                        case (heldClass)
                            C_LD:     begin cu.enableMDR = 1'b1; cu.MDR_read = 3'd1; end
                            C_ST:     begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.enableMDR = 1'b1; end
                            C_MULDIV: begin cu.ZHighout = 1'b1; cu.enableHI = 1'b1; end
                            C_BR:     begin cu.ZLowout = 1'b1; cu.enablePC = cu.CON_FF; end
                            default:  ;
                        endcase
                    end
                    default: begin
                        case (heldClass)
                            C_LD:    begin cu.MDRout = 1'b1; cu.Gra = 1'b1; cu.R_enable = 1'b1; end
                            C_ST:    cu.RAM_write = 1'b1;
                            default: ;
                        endcase
                    end
                endcase
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench for the Mini-SRC control sequencer.
// Expected strobe words come from a per-opcode step table built from the
// instruction descriptions; a negedge monitor pops and compares each cycle.
module tb_control_unit;
    localparam logic [31:0] RUN      = 32'd1 << 0;
    localparam logic [31:0] PCOUT    = 32'd1 << 1;
    localparam logic [31:0] ZLO      = 32'd1 << 2;
    localparam logic [31:0] ZHI      = 32'd1 << 3;
    localparam logic [31:0] MDROUT   = 32'd1 << 4;
    localparam logic [31:0] HIOUT    = 32'd1 << 5;
    localparam logic [31:0] LOOUT    = 32'd1 << 6;
    localparam logic [31:0] INPOUT   = 32'd1 << 7;
    localparam logic [31:0] COUT     = 32'd1 << 8;
    localparam logic [31:0] BAOUT    = 32'd1 << 9;
    localparam logic [31:0] ROUT     = 32'd1 << 10;
    localparam logic [31:0] GRA      = 32'd1 << 11;
    localparam logic [31:0] GRB      = 32'd1 << 12;
    localparam logic [31:0] GRC      = 32'd1 << 13;
    localparam logic [31:0] REN      = 32'd1 << 14;
    localparam logic [31:0] R15IN    = 32'd1 << 15;
    localparam logic [31:0] ENMAR    = 32'd1 << 16;
    localparam logic [31:0] ENMDR    = 32'd1 << 17;
    localparam logic [31:0] ENIR     = 32'd1 << 18;
    localparam logic [31:0] ENY      = 32'd1 << 19;
    localparam logic [31:0] ENZ      = 32'd1 << 20;
    localparam logic [31:0] ENPC     = 32'd1 << 21;
    localparam logic [31:0] ENHI     = 32'd1 << 22;
    localparam logic [31:0] ENLO     = 32'd1 << 23;
    localparam logic [31:0] ENCON    = 32'd1 << 24;
    localparam logic [31:0] ENINP    = 32'd1 << 25;
    localparam logic [31:0] ENOUTP   = 32'd1 << 26;
    localparam logic [31:0] RAMW     = 32'd1 << 27;
    localparam logic [31:0] INCPC    = 32'd1 << 28;
    localparam logic [31:0] MDRRD1   = 32'd1 << 29;

    localparam logic [31:0] T0WORD = RUN | PCOUT | ENMAR | INCPC | ENZ;

    localparam int K_START     = 0;
    localparam int K_HALTED    = 1;
    localparam int K_RESETTING = 2;

    logic clk;
    logic clr;
    control_unit_if bus ();

    control_unit dut (
        .clk (clk),
        .clr (clr),
        .cu  (bus)
    );

    logic [31:0] sb[$];
    logic [31:0] instrWords[$];
    int          errors    = 0;
    int          checks    = 0;
    int          cycleNo   = 0;
    int          modelKind = K_RESETTING;
    bit          monitorOn = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gathers the DUT strobes into the same bit layout as the expectation words.
    function automatic logic [31:0] packOutputs();
        logic [31:0] w;
        w = '0;
        w[0]  = bus.run;       w[1]  = bus.PCout;        w[2]  = bus.ZLowout;
        w[3]  = bus.ZHighout;  w[4]  = bus.MDRout;       w[5]  = bus.HIout;
        w[6]  = bus.LOout;     w[7]  = bus.InPortout;    w[8]  = bus.Cout;
        w[9]  = bus.BAout;     w[10] = bus.Rout;         w[11] = bus.Gra;
        w[12] = bus.Grb;       w[13] = bus.Grc;          w[14] = bus.R_enable;
        w[15] = bus.R15in;     w[16] = bus.enableMAR;    w[17] = bus.enableMDR;
        w[18] = bus.enableIR;  w[19] = bus.enableY;      w[20] = bus.enableZ;
        w[21] = bus.enablePC;  w[22] = bus.enableHI;     w[23] = bus.enableLO;
        w[24] = bus.enableCON; w[25] = bus.enableInPort; w[26] = bus.enableOutPort;
        w[27] = bus.RAM_write; w[28] = bus.IncPC;        w[31:29] = bus.MDR_read;
        return w;
    endfunction

    // Whole-instruction strobe sequence, written straight from the instruction table.
    function automatic void buildInstr(input logic [4:0] op, input bit con);
        int          n;
        logic [31:0] ex[$];
        n = int'(op);
        instrWords.delete();
        instrWords.push_back(T0WORD);
        instrWords.push_back(RUN | ZLO | ENPC | ENMDR | MDRRD1);
        instrWords.push_back(RUN | MDROUT | ENIR);
        if (n >= 3 && n <= 10)        ex = '{GRB|ROUT|ENY, GRC|ROUT|ENZ, ZLO|GRA|REN};
        else if (n >= 11 && n <= 13)  ex = '{GRB|ROUT|ENY, COUT|ENZ, ZLO|GRA|REN};
        else if (n == 1)              ex = '{GRB|BAOUT|ENY, COUT|ENZ, ZLO|GRA|REN};
        else if (n == 0)              ex = '{GRB|BAOUT|ENY, COUT|ENZ, ZLO|ENMAR, ENMDR|MDRRD1, MDROUT|GRA|REN};
        else if (n == 2)              ex = '{GRB|BAOUT|ENY, COUT|ENZ, ZLO|ENMAR, GRA|ROUT|ENMDR, RAMW};
        else if (n == 14 || n == 15)  ex = '{GRA|ROUT|ENY, GRB|ROUT|ENZ, ZLO|ENLO, ZHI|ENHI};
        else if (n == 16 || n == 17)  ex = '{GRB|ROUT|ENZ, ZLO|GRA|REN};
        else if (n == 18)             ex = '{GRA|ROUT|ENCON, PCOUT|ENY, COUT|ENZ, ZLO|(con ? ENPC : 32'd0)};
        else if (n == 19)             ex = '{GRA|ROUT|ENPC};
        else if (n == 20)             ex = '{PCOUT|R15IN, GRA|ROUT|ENPC};
        else if (n == 21)             ex = '{INPOUT|GRA|REN};
        else if (n == 22)             ex = '{GRA|ROUT|ENOUTP};
        else if (n == 23)             ex = '{HIOUT|GRA|REN};
        else if (n == 24)             ex = '{LOOUT|GRA|REN};
        foreach (ex[i]) instrWords.push_back(RUN | ex[i]);
    endfunction

    // Queues the expectation for the current cycle, then lets one clock edge pass.
    task automatic applyStimulus(input logic [31:0] exp);
        sb.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    // Pops the oldest expectation and compares it with what the DUT shows now.
    task automatic checkOutput();
        logic [31:0] exp;
        logic [31:0] got;
        checks++;
        got = packOutputs();
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard cycle %0d: got %h but nothing was expected", cycleNo, got);
        end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL ctrl cycle %0d: got %h want %h (diff %h)", cycleNo, got, exp, got ^ exp);
            end
        end
        cycleNo++;
    endtask

    // Monitor samples midway between active edges.
    always @(negedge clk) begin
        if (monitorOn) checkOutput();
    end

    // Holds clr low for n edges, then releases it for the edge that enters T0.
    task automatic resetFor(input int n);
        for (int k = 0; k < n; k++) begin
            clr        = 1'b0;
            bus.stop   = 1'($urandom_range(0, 1));
            bus.opcode = 5'($urandom);
            bus.CON_FF = 1'($urandom_range(0, 1));
            applyStimulus((k == 0 && modelKind == K_START) ? T0WORD : 32'd0);
        end
        clr = 1'b1;
        applyStimulus(32'd0);
        modelKind = K_START;
    endtask

    // Idles in HALT while the inputs wander; nothing but clr may leave it.
    task automatic haltHold(input int n);
        for (int k = 0; k < n; k++) begin
            clr        = 1'b1;
            bus.stop   = 1'($urandom_range(0, 1));
            bus.opcode = 5'($urandom);
            bus.CON_FF = 1'($urandom_range(0, 1));
            applyStimulus(32'd0);
        end
    endtask

    // One instruction from T0; stop is raised from stopIdx on, clr dropped at clrIdx.
    task automatic runInstr(input logic [4:0] op, input bit con, input int stopIdx, input int clrIdx);
        bit lastStop;
        lastStop = 1'b0;
        buildInstr(op, con);
        bus.opcode = op;
        for (int i = 0; i < instrWords.size(); i++) begin
            clr        = (i == clrIdx) ? 1'b0 : 1'b1;
            bus.stop   = (stopIdx >= 0 && i >= stopIdx);
            bus.CON_FF = (i == 6) ? con : 1'($urandom_range(0, 1));
            lastStop   = bus.stop;
            applyStimulus(instrWords[i]);
            if (i == 2) bus.opcode = 5'($urandom);
            if (i == clrIdx) begin
                modelKind = K_RESETTING;
                return;
            end
        end
        modelKind = (op == 5'b11010 || lastStop) ? K_HALTED : K_START;
    endtask

    // Brings the model back to an instruction boundary after HALT or a reset abort.
    task automatic settle();
        if (modelKind == K_HALTED) begin
            haltHold($urandom_range(2, 12));
            resetFor($urandom_range(1, 2));
        end else if (modelKind == K_RESETTING) begin
            resetFor(1);
        end
    endtask

    initial begin
        clr        = 1'b0;
        bus.stop   = 1'b0;
        bus.opcode = 5'd0;
        bus.CON_FF = 1'b0;
        @(posedge clk);
        #1;
        monitorOn = 1'b1;
        modelKind = K_RESETTING;
        $display("[TB] reset and directed instructions");
        resetFor(2);
        runInstr(5'b00011, 1'b0, -1, -1); settle();
        runInstr(5'b00000, 1'b1, -1, -1); settle();
        runInstr(5'b10010, 1'b1, -1, -1); settle();
        runInstr(5'b10010, 1'b0, -1, -1); settle();
        runInstr(5'b11010, 1'b0, -1, -1);
        haltHold(12);
        resetFor(1);
        runInstr(5'b01110, 1'b0, -1, 4);  settle();
        runInstr(5'b00011, 1'b0, 3, -1);
        haltHold(10);
        resetFor(1);
        runInstr(5'b11001, 1'b0, 2, -1);  settle();

        $display("[TB] opcode sweep");
        for (int op = 0; op < 32; op++) begin
            runInstr(5'(op), 1'($urandom_range(0, 1)), -1, -1);
            settle();
        end

        $display("[TB] randomized instruction stream");
        for (int n = 0; n < 200; n++) begin
            int stopIdx;
            int clrIdx;
            stopIdx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
            clrIdx  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 7)) : -1;
            runInstr(5'($urandom), 1'($urandom_range(0, 1)), stopIdx, clrIdx);
            settle();
        end

        monitorOn = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Hardwired control sequencer for the Mini-SRC CPU. It sits directly upstream of the datapath and drives every datapath control strobe now driven by hand in benches. It decodes the datapath's IR opcode and CON_FF flag and steps through fetch (T0–T2) and per-instruction execute steps (T3–T7), one step per clock.

Parameters:
- RESET_PC_LOAD, 0, reserved; must stay 0 (PC reset is handled by the datapath).
- OPW, 5, opcode width.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- clr  in  1  synchronous, active-low reset.
- opcode  in  5  IR[31:27] from datapath.
- CON_FF  in  1  branch-condition flop from datapath.
- stop  in  1  external halt request.
- run  out  1  high while executing; low in RESET and HALT.
- PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout  out  1 each  bus-source selects.
- Gra, Grb, Grc  out  1 each  IR register-field selects.
- R_enable  out  1  write the selected GPR.
- R15in  out  1  write R15 (jal link).
- enableMAR, enableMDR, enableIR, enableY, enableZ, enablePC, enableHI, enableLO, enableCON, enableInPort, enableOutPort  out  1 each  register load enables.
- MDR_read  out  3  MDR source: 0 = BusMuxOut, 1 = memory, 2 = Mdatain (never driven to 2).
- RAM_write  out  1  memory write strobe.
- IncPC  out  1  ALU PC+1 mode.

Behaviour:
- States: RESET, T0–T7, HALT. Outputs are a combinational (Moore) decode of state plus latched opcode/CON_FF. Unlisted outputs are 0; MDR_read defaults to 0.
- clr = 0 at a posedge forces RESET from any state, including mid-instruction. All outputs are 0 and run = 0 for that cycle. The next posedge with clr = 1 enters T0.
- Fetch:
  - T0: PCout, enableMAR, IncPC, enableZ.
  - T1: ZLowout, enablePC, enableMDR, MDR_read = 1.
  - T2: MDRout, enableIR.
- opcode is sampled into an internal register at the T2→T3 edge. The execute steps use only this latched copy.
- After the last listed step of an instruction, the next state is T0. If stop = 1 at that edge, the next state is HALT instead. HALT is held until clr.
- Execute steps, by opcode:
  - add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010:
    - T3: Grb, Rout, enableY.
    - T4: Grc, Rout, enableZ.
    - T5: ZLowout, Gra, R_enable.
  - addi 01011, andi 01100, ori 01101:
    - T3: Grb, Rout, enableY.
    - T4: Cout, enableZ.
    - T5: ZLowout, Gra, R_enable.
  - ldi 00001:
    - T3: Grb, BAout, enableY.
    - T4: Cout, enableZ.
    - T5: ZLowout, Gra, R_enable.
  - ld 00000:
    - T3–T4 as ldi.
    - T5: ZLowout, enableMAR.
    - T6: enableMDR, MDR_read = 1.
    - T7: MDRout, Gra, R_enable.
  - st 00010:
    - T3–T4 as ldi.
    - T5: ZLowout, enableMAR.
    - T6: Gra, Rout, enableMDR, MDR_read = 0.
    - T7: RAM_write.
  - mul 01110, div 01111:
    - T3: Gra, Rout, enableY.
    - T4: Grb, Rout, enableZ.
    - T5: ZLowout, enableLO.
    - T6: ZHighout, enableHI.
  - neg 10000, not 10001:
    - T3: Grb, Rout, enableZ.
    - T4: ZLowout, Gra, R_enable.
  - br 10010:
    - T3: Gra, Rout, enableCON.
    - T4: PCout, enableY.
    - T5: Cout, enableZ.
    - T6: ZLowout, and enablePC only if CON_FF = 1 at T6. T6 is always visited.
  - jr 10011:
    - T3: Gra, Rout, enablePC.
  - jal 10100:
    - T3: PCout, R15in.
    - T4: Gra, Rout, enablePC.
  - in 10101:
    - T3: InPortout, Gra, R_enable.
  - out 10110:
    - T3: Gra, Rout, enableOutPort.
  - mfhi 10111:
    - T3: HIout, Gra, R_enable.
  - mflo 11000:
    - T3: LOout, Gra, R_enable.
  - nop 11001, and any undefined opcode (11011–11111): T2 → T0.
  - halt 11010: T2 → HALT.
- Invariants: at most one bus-source select is high in any state. run = 1 in T0–T7.
- A stop request is honoured only at an instruction boundary. Reset overrides stop and halt.

Test Plan:
- Reset: hold clr = 0 for 2 cycles → all outputs 0, run = 0. Release → next cycle T0 with PCout = enableMAR = IncPC = enableZ = 1.
- add (opcode 00011) → T3 Grb/Rout/enableY, T4 Grc/Rout/enableZ, T5 ZLowout/Gra/R_enable, then T0. Total 6 cycles from T0 to the next T0.
- ld (00000) → T6 MDR_read = 1 with enableMDR; T7 MDRout/Gra/R_enable; then T0 (8-cycle instruction).
- br (opcode bits 10010, e.g. IR 91100023):
  - CON_FF = 1 at T6 → enablePC = 1 with ZLowout.
  - CON_FF = 0 → enablePC = 0 at T6, then T0.
- halt (11010) → HALT after T2, run = 0, outputs stay 0 for 10+ cycles. clr = 0 → RESET, then T0.
- Boundaries:
  - clr = 0 during T4 of mul → RESET next cycle, enableHI never asserted.
  - stop = 1 mid-instruction → the instruction completes, then HALT.
